// File: rtl/ga23_palette_mixer.sv
// rtl/ga23_palette_mixer.sv - GA23 tile/sprite mixer with shared palette RAM and CPU arbitration
//
// Purpose:
//   Picks the tilemap or sprite pixel, looks its colour up in a single-port
//   palette RAM and emits 8-bit RGB with matching blank/sync. The CPU shares
//   the RAM and is served only in clk cycles where ce_pix is low.
//
// Ports:
//   clk, reset                      system clock, asynchronous active-high reset
//   ce_pix                          pixel enable (never high two clk in a row)
//   tile_color, tile_prio           tilemap pixel {palette[6:0], index[3:0]} and priority
//   obj_color                       sprite pixel {palette[6:0], index[3:0]}
//   pal_bank                        ORed into palette address bit 10
//   hblank_in..vsync_in             timing from the tilemap stage
//   cpu_cs/rd/wr/addr/din           CPU palette access request (one-clk strobes)
//   cpu_dout, busy                  CPU read data, access pending
//   r, g, b                         pixel colour, 3 ce_pix ticks after input
//   hblank, vblank, hsync, vsync    timing delayed to match r/g/b

module ga23_palette_mixer #(
  parameter int PAL_WORDS = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic [10:0] tile_color,
  input  logic        tile_prio,
  input  logic [10:0] obj_color,
  input  logic        pal_bank,
  input  logic        hblank_in,
  input  logic        vblank_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        cpu_cs,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [10:0] cpu_addr,
  input  logic [15:0] cpu_din,
  output logic [15:0] cpu_dout,
  output logic        busy,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        hblank,
  output logic        vblank,
  output logic        hsync,
  output logic        vsync
);

  localparam int AW = $clog2(PAL_WORDS);

  typedef enum logic {ST_IDLE, ST_PEND} cpu_state_t;

  // Mixer
  logic          w_obj_opaque;
  logic          w_tile_opaque;
  logic          w_sel_obj;
  logic [9:0]    w_color;
  logic [10:0]   w_addr_full;
  logic [AW-1:0] w_pix_addr;

  assign w_obj_opaque  = |obj_color[3:0];
  assign w_tile_opaque = |tile_color[3:0];
  assign w_sel_obj     = w_obj_opaque && !(tile_prio && w_tile_opaque);
  assign w_color       = w_sel_obj ? obj_color[9:0] : tile_color[9:0];
  assign w_addr_full   = {w_sel_obj | pal_bank, w_color};
  assign w_pix_addr    = w_addr_full[AW-1:0];

  // Colour bit 10 never reaches the address; upper address bits drop for small RAMs.
  logic w_unused;
  assign w_unused = &{1'b0, tile_color[10], obj_color[10], w_addr_full, cpu_addr};

  // CPU arbitration
  cpu_state_t    r_state;
  cpu_state_t    w_state_nxt;
  logic          r_req_d;
  logic          w_req;
  logic          w_req_rise;
  logic          w_latch;
  logic          w_cpu_go;
  logic [AW-1:0] r_cpu_addr;
  logic [15:0]   r_cpu_din;
  logic          r_cpu_we;
  logic          r_rd_cap;
  logic [15:0]   r_cpu_dout;

  assign w_req      = cpu_cs & (cpu_rd | cpu_wr);
  assign w_req_rise = w_req & ~r_req_d;

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_cpu_go    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req_rise) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        // The pixel read owns every ce_pix clk; the CPU takes the next free one.
        if (!ce_pix) begin
          w_cpu_go    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_req_d    <= 1'b0;
      r_cpu_addr <= '0;
      r_cpu_din  <= '0;
      r_cpu_we   <= 1'b0;
      r_rd_cap   <= 1'b0;
      r_cpu_dout <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req_d <= w_req;
      if (w_latch) begin
        r_cpu_addr <= cpu_addr[AW-1:0];
        r_cpu_din  <= cpu_din;
        r_cpu_we   <= cpu_wr;
      end
      r_rd_cap <= w_cpu_go && !r_cpu_we;
      if (r_rd_cap) begin
        r_cpu_dout <= r_ram_q;
      end
    end
  end

  // busy also covers the clk in which read data lands in cpu_dout.
  assign busy     = (r_state == ST_PEND) || r_rd_cap;
  assign cpu_dout = r_cpu_dout;

  // Palette RAM: single port, registered read data
  logic [15:0]   r_mem [PAL_WORDS];
  logic [15:0]   r_ram_q;
  logic [AW-1:0] w_ram_addr;
  logic          w_ram_we;

  assign w_ram_addr = ce_pix ? w_pix_addr : r_cpu_addr;
  assign w_ram_we   = w_cpu_go && r_cpu_we;

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_mem[w_ram_addr] <= r_cpu_din;
    end
    if (ce_pix || (w_cpu_go && !r_cpu_we)) begin
      r_ram_q <= r_mem[w_ram_addr];
    end
  end

  // Pixel pipeline
  logic        r_pix_rd;
  logic [14:0] r_pix_hold;
  logic        r_s1_valid;
  logic [3:0]  r_s1_tm;
  logic        r_s2_valid;
  logic [3:0]  r_s2_tm;
  logic [14:0] r_s2_w;
  logic [3:0]  r_s3_tm;
  logic [7:0]  r_red;
  logic [7:0]  r_grn;
  logic [7:0]  r_blu;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pix_rd   <= 1'b0;
      r_pix_hold <= '0;
      r_s1_valid <= 1'b0;
      r_s1_tm    <= '0;
      r_s2_valid <= 1'b0;
      r_s2_tm    <= '0;
      r_s2_w     <= '0;
      r_s3_tm    <= '0;
      r_red      <= '0;
      r_grn      <= '0;
      r_blu      <= '0;
    end else begin
      // Park the pixel word on the clk after its read, before a CPU read
      // can reuse the RAM output register.
      r_pix_rd <= ce_pix;
      if (r_pix_rd) begin
        r_pix_hold <= r_ram_q[14:0];
      end
      if (ce_pix) begin
        r_s1_valid <= 1'b1;
        r_s1_tm    <= {hblank_in, vblank_in, hsync_in, vsync_in};
        r_s2_valid <= r_s1_valid;
        r_s2_tm    <= r_s1_tm;
        r_s2_w     <= r_pix_hold;
        r_s3_tm    <= r_s2_tm;
        if (r_s2_valid && !r_s2_tm[3] && !r_s2_tm[2]) begin
          r_red <= {r_s2_w[4:0],   r_s2_w[4:2]};
          r_grn <= {r_s2_w[9:5],   r_s2_w[9:7]};
          r_blu <= {r_s2_w[14:10], r_s2_w[14:12]};
        end else begin
          r_red <= '0;
          r_grn <= '0;
          r_blu <= '0;
        end
      end
    end
  end

  assign r      = r_red;
  assign g      = r_grn;
  assign b      = r_blu;
  assign hblank = r_s3_tm[3];
  assign vblank = r_s3_tm[2];
  assign hsync  = r_s3_tm[1];
  assign vsync  = r_s3_tm[0];

endmodule

// File: tb/tb_ga23_palette_mixer.sv
// tb/tb_ga23_palette_mixer.sv - scoreboard bench for ga23_palette_mixer

module tb_ga23_palette_mixer;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce_pix;
  logic [10:0] tile_color;
  logic        tile_prio;
  logic [10:0] obj_color;
  logic        pal_bank;
  logic        hblank_in, vblank_in, hsync_in, vsync_in;
  logic        cpu_cs, cpu_rd, cpu_wr;
  logic [10:0] cpu_addr;
  logic [15:0] cpu_din;
  logic [15:0] cpu_dout;
  logic        busy;
  logic [7:0]  r, g, b;
  logic        hblank, vblank, hsync, vsync;

  always #5 clk = ~clk;

  ga23_palette_mixer #(.PAL_WORDS(2048)) dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix),
    .tile_color(tile_color), .tile_prio(tile_prio), .obj_color(obj_color),
    .pal_bank(pal_bank),
    .hblank_in(hblank_in), .vblank_in(vblank_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .cpu_cs(cpu_cs), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .busy(busy),
    .r(r), .g(g), .b(b),
    .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync)
  );

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hb;
    logic       vb;
    logic       hs;
    logic       vs;
  } pix_t;

  pix_t        exp_q[$];
  logic [15:0] model [2048];
  int          n_pass  = 0;
  int          n_total = 0;
  int          n_fail  = 0;
  int          busy_run = 0;
  int          busy_max = 0;

  always @(negedge clk) begin
    if (busy === 1'b1) busy_run++;
    else busy_run = 0;
    if (busy_run > busy_max) busy_max = busy_run;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic pix_t model_pix();
    logic        sel;
    logic [10:0] a;
    logic [15:0] w;
    pix_t        p;
    sel = (obj_color[3:0] != 4'd0) && !(tile_prio && (tile_color[3:0] != 4'd0));
    if (sel) a = {1'b1, obj_color[9:0]};
    else     a = {pal_bank, tile_color[9:0]};
    w = model[a];
    p.hb = hblank_in;
    p.vb = vblank_in;
    p.hs = hsync_in;
    p.vs = vsync_in;
    if (hblank_in || vblank_in) begin
      p.r = 8'd0;
      p.g = 8'd0;
      p.b = 8'd0;
    end else begin
      p.r = {w[4:0],   w[4:2]};
      p.g = {w[9:5],   w[9:7]};
      p.b = {w[14:10], w[14:12]};
    end
    return p;
  endfunction

  task automatic prefill();
    exp_q.delete();
    exp_q.push_back('0);
    exp_q.push_back('0);
  endtask

  // One pixel period: a ce_pix clk followed by a non-ce clk, optionally
  // issuing a CPU request on the ce clk.
  task automatic pstep(input bit go = 1'b0, input bit we = 1'b0,
                       input logic [10:0] a = 11'd0, input logic [15:0] d = 16'd0);
    pix_t got;
    pix_t e;
    @(negedge clk);
    ce_pix = 1'b1;
    if (go) begin
      cpu_cs   = 1'b1;
      cpu_wr   = we;
      cpu_rd   = !we;
      cpu_addr = a;
      cpu_din  = d;
    end
    @(posedge clk);
    exp_q.push_back(model_pix());
    if (go && we) model[a] = d;
    #1;
    if (go) check("busy_rise", {31'd0, busy}, 32'd1);
    got = {r, g, b, hblank, vblank, hsync, vsync};
    e   = exp_q.pop_front();
    check("pixel", {4'd0, got}, {4'd0, e});
    @(negedge clk);
    ce_pix = 1'b0;
    cpu_cs = 1'b0;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4 && busy === 1'b1; i++) pstep();
    check("busy_clear", {31'd0, busy}, 32'd0);
  endtask

  task automatic cpu_write(input logic [10:0] a, input logic [15:0] d);
    pstep(1'b1, 1'b1, a, d);
    wait_idle();
  endtask

  task automatic cpu_read(input logic [10:0] a, input logic [15:0] exp);
    pstep(1'b1, 1'b0, a, 16'd0);
    wait_idle();
    pstep();
    check("readback", {16'd0, cpu_dout}, {16'd0, exp});
  endtask

  initial begin
    reset = 1'b1;
    ce_pix = 1'b0;
    tile_color = '0; tile_prio = 1'b0; obj_color = '0; pal_bank = 1'b0;
    hblank_in = 1'b1; vblank_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    cpu_cs = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_din = '0;
    for (int i = 0; i < 2048; i++) model[i] = 16'd0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_rgb", {8'd0, r, g, b}, 32'd0);
    check("reset_timing", {28'd0, hblank, vblank, hsync, vsync}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_dout", {16'd0, cpu_dout}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    prefill();

    // Preload under hblank so reads of not-yet-written words stay black.
    cpu_write(11'h000, 16'h7FFF);
    cpu_write(11'h012, 16'h001F);
    cpu_write(11'h412, 16'h7C00);
    cpu_write(11'h013, 16'h03E0);
    cpu_write(11'h405, 16'h4210);
    cpu_write(11'h7FF, 16'h03E0);
    cpu_write(11'h100, 16'hAAAA);
    hblank_in = 1'b0;

    tile_color = 11'h000; obj_color = 11'h000;
    repeat (10) pstep();

    tile_color = 11'h012; obj_color = 11'h012; tile_prio = 1'b0;
    repeat (4) pstep();
    tile_prio = 1'b1;
    repeat (4) pstep();

    tile_color = 11'h013; obj_color = 11'h010; tile_prio = 1'b0;
    repeat (4) pstep();

    pal_bank = 1'b1; tile_color = 11'h005; obj_color = 11'h000;
    repeat (3) pstep();
    hblank_in = 1'b1;
    repeat (2) pstep();
    hblank_in = 1'b0; vblank_in = 1'b1; hsync_in = 1'b1;
    repeat (2) pstep();
    vblank_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b1;
    repeat (2) pstep();
    vsync_in = 1'b0; pal_bank = 1'b0;
    repeat (3) pstep();

    // Write to the word being displayed: same period sees old, later see new.
    tile_color = 11'h000; obj_color = 11'h3FF;
    repeat (3) pstep();
    pstep(1'b1, 1'b1, 11'h7FF, 16'h1234);
    wait_idle();
    repeat (3) pstep();
    cpu_read(11'h7FF, 16'h1234);
    repeat (3) pstep();

    // Reset during a pending write drops it.
    @(negedge clk);
    ce_pix = 1'b1; cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_addr = 11'h100; cpu_din = 16'h5555;
    @(posedge clk);
    #1;
    check("busy_before_reset", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("reset_mid_busy", {31'd0, busy}, 32'd0);
    check("reset_mid_rgb", {8'd0, r, g, b}, 32'd0);
    check("reset_mid_timing", {28'd0, hblank, vblank, hsync, vsync}, 32'd0);
    @(negedge clk);
    ce_pix = 1'b0; cpu_cs = 1'b0; cpu_wr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    prefill();
    cpu_read(11'h100, 16'hAAAA);
    repeat (4) pstep();

    check("busy_max_le3", {31'd0, busy_max <= 3}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ga23_palette_mixer.md
Name: ga23_palette_mixer

Overview:
- Pixel stage directly downstream of the GA23 tilemap generator.
- Merges the tilemap pixel (11-bit colour + priority) with the sprite pixel and looks the result up in an internal single-port 2048x16 palette RAM.
- The palette RAM is shared with CPU read/write; CPU access is arbitrated into the clk cycles where ce_pix is low.
- Emits 24-bit RGB plus delay-matched blank/sync to the video output.

Parameters:
- PAL_WORDS, 2048: palette RAM depth; must be a power of 2, at most 2048.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- ce_pix  in  1  pixel enable; never high on two consecutive clk cycles.
- tile_color  in  11  tilemap colour {palette[6:0], index[3:0]}.
- tile_prio  in  1  tilemap pixel priority over sprites.
- obj_color  in  11  sprite colour {palette[6:0], index[3:0]}.
- pal_bank  in  1  palette bank select; inverts nothing, is ORed into RAM address bit 10.
- hblank_in, vblank_in, hsync_in, vsync_in  in  1 each  timing from the tilemap stage.
- cpu_cs  in  1  palette RAM select.
- cpu_rd  in  1  read strobe, one clk.
- cpu_wr  in  1  write strobe, one clk.
- cpu_addr  in  11  word address.
- cpu_din  in  16  write data.
- cpu_dout  out  16  read data.
- busy  out  1  CPU access pending.
- r, g, b  out  8 each  pixel colour.
- hblank, vblank, hsync, vsync  out  1 each  delayed timing.

Behaviour:
Reset:
- r, g, b = 0; cpu_dout = 0; busy = 0; all timing outputs = 0; pipeline valid bits cleared.
- Reset asserted mid-CPU-access drops the access; no RAM write occurs after reset asserts.

Mix (comb, sampled at stage 1):
- obj_opaque = |obj_color[3:0]; tile_opaque = |tile_color[3:0].
- Select the sprite when obj_opaque && !(tile_prio && tile_opaque); otherwise select the tile. Sprite selection adds 0x400 (bit 10 set) to the RAM address.
- RAM address = {sel_is_obj | pal_bank, colour[9:0]} masked to log2(PAL_WORDS) bits.

Pixel pipeline (advances only on clk with ce_pix=1):
- S1: register address and timing inputs, and drive the RAM read on that same clk.
- S2: register RAM data word w.
- S3:
  - r = {w[4:0], w[4:2]}, g = {w[9:5], w[9:7]}, b = {w[14:10], w[14:12]}; w[15] is ignored.
  - r, g, b are forced to 0 when the delayed hblank or vblank is set.
  - Timing outputs are delayed identically.
- Total latency: 3 ce_pix ticks, input to output.

CPU arbitration (state machine IDLE -> PEND -> IDLE):
- A rising cpu_cs & (cpu_rd|cpu_wr) latches addr, data and we, moves to PEND, and sets busy=1 in the next clk.
- In PEND, on the first clk with ce_pix=0: perform the RAM access (write, or read captured into cpu_dout in the following clk), then return to IDLE and clear busy.
- Worst-case busy duration: 3 clk.
- A request while in PEND is ignored; the CPU must wait on busy.
- Simultaneous request and ce_pix: the pixel read wins and the CPU access goes on the next non-ce clk.
- A CPU write to an address being read by the pixel pipe in the same pixel period: the pixel sees the old data; the next pixel sees the new data.

Test Plan:
- Reset, then 10 ce_pix ticks with tile_color=0 and obj_color=0: RAM[0]=0x7FFF preloaded via CPU, output r=g=b=0xFF appears exactly 3 ticks after input.
- Write RAM[0x012]=0x001F and RAM[0x412]=0x7C00:
  - tile_color=0x012, obj_color=0x012, tile_prio=0 -> b=0xFF, r=0.
  - tile_prio=1 -> r=0xFF, b=0.
- obj_color=0x010 (transparent), tile_color=0x013, tile_prio=0 -> tile path chosen, address 0x013.
- pal_bank=1, tile_color=0x005 -> address 0x405 read; with hblank_in=1 -> rgb=0 three ticks later and hblank=1 aligned.
- CPU write 0x1234 to 0x7FF with ce_pix every 2nd clk, issued on a ce clk:
  - busy rises next clk and clears within 3 clk.
  - Read back gives cpu_dout=0x1234.
  - Pixel output stream is undisturbed throughout.
- Assert reset while busy=1 during a write to 0x100 (old value 0xAAAA): busy=0 and r=g=b=0 immediately; readback of 0x100 = 0xAAAA.
